// File: rtl/spi_regfile_peripheral.sv
// spi_regfile_peripheral
//
// SPI mode-0 target that exposes a bank of NUM_REGS control registers, each DATA_W bits wide.
// A frame is 1 + ADDR_W + DATA_W bits long and is sent MSB first:
//   {R/W (1 = write), address[ADDR_W-1:0], data[DATA_W-1:0]}.
// A register changes only when a complete, well-formed write frame ends. A frame that is short,
// over-long or addressed out of range is dropped, and frame_err pulses for one cycle.
//
// Optional feature (define SPI_READBACK_EN): a read frame returns reg[addr] on cipo during the
// data phase. When the macro is undefined, cipo and cipo_oe are tied low and read frames are
// accepted and ignored.
//
// Ports
//   clk        system clock; the only clock used
//   rst_n      synchronous active-low reset
//   sclk       SPI clock from the controller (asynchronous)
//   copi       controller-out data (asynchronous)
//   ncs        active-low chip select (asynchronous)
//   cipo       controller-in data
//   cipo_oe    high while cipo is driven
//   regs_out   flattened registers; reg i at [i*DATA_W +: DATA_W]
//   wr_pulse   one-cycle pulse when a write commits
//   wr_addr    address of the last committed write
//   frame_err  one-cycle pulse when a frame is discarded

module spi_regfile_peripheral #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int unsigned FrameLen = 1 + ADDR_W + DATA_W;
    localparam int unsigned CmdLen   = 1 + ADDR_W;
    localparam int unsigned CntW     = $clog2(FrameLen + 1);
    localparam int unsigned FlushW   = $clog2(SYNC_STAGES + 1);
    localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StWait} state_e;

    // ------------------------------------------------------------------
    // Input synchronisers, history flops and registered edge flags
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
    logic                   sclk_hist_q, ncs_hist_q;
    logic                   sclk_rise_q, ncs_rise_q, ncs_fall_q, copi_bit_q;
`ifdef SPI_READBACK_EN
    logic                   sclk_fall_q;
`endif
    logic                   sclk_s, ncs_s, copi_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            sclk_rise_q <= 1'b0;
            ncs_rise_q  <= 1'b0;
            ncs_fall_q  <= 1'b0;
            copi_bit_q  <= 1'b0;
`ifdef SPI_READBACK_EN
            sclk_fall_q <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            sclk_hist_q <= sclk_s;
            ncs_hist_q  <= ncs_s;
            sclk_rise_q <= sclk_s & ~sclk_hist_q;
            ncs_rise_q  <= ncs_s & ~ncs_hist_q;
            ncs_fall_q  <= ~ncs_s & ncs_hist_q;
            // Registered alongside sclk_rise_q so the data bit lines up with its edge flag.
            copi_bit_q  <= copi_s;
`ifdef SPI_READBACK_EN
            sclk_fall_q <= ~sclk_s & sclk_hist_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Re-arm after reset. The synchroniser reset value reads as "ncs high",
    // so wait until the chain holds real samples and then see a real high
    // level on ncs. Until then a frame cut by reset cannot be decoded.
    // ------------------------------------------------------------------
    logic [FlushW-1:0] flush_q;
    logic              flush_done;
    logic              armed_q;

    assign flush_done = (flush_q == FlushW'(SYNC_STAGES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_q <= '0;
            armed_q <= 1'b0;
        end else begin
            if (!flush_done) begin
                flush_q <= flush_q + 1'b1;
            end
            if (flush_done && ncs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and register bank
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FrameLen-1:0] rx_q, rx_d, rx_next;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                frame_err_q, frame_err_d;
    logic [CntW-1:0]     cnt_next;
    logic                frame_rw;
    logic [ADDR_W-1:0]   frame_addr;
    logic [DATA_W-1:0]   frame_data;
`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                rd_ok_q, rd_ok_d;
    logic                cmd_rw_next;
    logic [ADDR_W-1:0]   cmd_addr_next;
`endif

    // All address bits take part in the range check; none are dropped.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NumRegsW;
    endfunction

    assign rx_next    = {rx_q[FrameLen-2:0], copi_bit_q};
    assign cnt_next   = bit_cnt_q + 1'b1;
    assign frame_rw   = rx_q[FrameLen-1];
    assign frame_addr = rx_q[DATA_W +: ADDR_W];
    assign frame_data = rx_q[DATA_W-1:0];
`ifdef SPI_READBACK_EN
    // Command fields as they will stand once the final command bit is shifted in.
    assign cmd_rw_next   = rx_next[ADDR_W];
    assign cmd_addr_next = rx_next[ADDR_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        ovf_d       = ovf_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
`ifdef SPI_READBACK_EN
        tx_d        = tx_q;
        rd_ok_d     = rd_ok_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (armed_q && ncs_fall_q) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    ovf_d     = 1'b0;
`ifdef SPI_READBACK_EN
                    tx_d      = '0;
                    rd_ok_d   = 1'b0;
`endif
                end
            end

            StCmd: begin
                // An ncs rise takes priority over an sclk rise in the same cycle.
                if (ncs_rise_q) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (sclk_rise_q) begin
                    rx_d      = rx_next;
                    bit_cnt_d = cnt_next;
                    if (cnt_next == CntW'(CmdLen)) begin
                        state_d = StData;
`ifdef SPI_READBACK_EN
                        if (!cmd_rw_next && addr_ok(cmd_addr_next)) begin
                            rd_ok_d = 1'b1;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if ({1'b0, cmd_addr_next} == (ADDR_W + 1)'(i)) begin
                                    tx_d = regs_q[i];
                                end
                            end
                        end
`endif
                    end
                end
            end

            StData: begin
                if (ncs_rise_q) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
`ifdef SPI_READBACK_EN
                    rd_ok_d     = 1'b0;
`endif
                end else if (sclk_rise_q) begin
                    rx_d      = rx_next;
                    bit_cnt_d = cnt_next;
                    if (cnt_next == CntW'(FrameLen)) begin
                        state_d = StWait;
                    end
`ifdef SPI_READBACK_EN
                end else if (sclk_fall_q && (bit_cnt_q != CntW'(CmdLen))) begin
                    // Skip the fall that precedes the first data rise so the loaded MSB
                    // stays on cipo for the controller's first data sample.
                    tx_d = tx_q << 1;
`endif
                end
            end

            StWait: begin
                if (ncs_rise_q) begin
                    state_d = StIdle;
`ifdef SPI_READBACK_EN
                    rd_ok_d = 1'b0;
`endif
                    if (ovf_q) begin
                        frame_err_d = 1'b1;
                    end else if (frame_rw) begin
                        if (addr_ok(frame_addr)) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if ({1'b0, frame_addr} == (ADDR_W + 1)'(i)) begin
                                    regs_d[i] = frame_data;
                                end
                            end
                            wr_pulse_d = 1'b1;
                            wr_addr_d  = frame_addr;
                        end else begin
                            frame_err_d = 1'b1;
                        end
`ifdef SPI_READBACK_EN
                    end else if (!addr_ok(frame_addr)) begin
                        frame_err_d = 1'b1;
`endif
                    end
                end else if (sclk_rise_q) begin
                    ovf_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            ovf_q       <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
`ifdef SPI_READBACK_EN
            tx_q        <= '0;
            rd_ok_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            ovf_q       <= ovf_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef SPI_READBACK_EN
            tx_q        <= tx_d;
            rd_ok_q     <= rd_ok_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
    assign cipo_oe = (state_q == StData) && rd_ok_q;
    assign cipo    = cipo_oe & tx_q[DATA_W-1];
`else
    assign cipo_oe = 1'b0;
    assign cipo    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral with default parameters.
// The controller holds each sclk phase for HALF clk cycles.
module tb_spi_regfile_peripheral;

    localparam int NR   = 8;
    localparam int DW   = 8;
    localparam int AW   = 7;
    localparam int SS   = 2;
    localparam int HALF = 8;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          copi = 1'b0;
    logic          ncs = 1'b1;
    logic          cipo, cipo_oe, wr_pulse, frame_err;
    logic [NR*DW-1:0] regs_out;
    logic [AW-1:0] wr_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int wr_rise  = 0;
    int err_cnt  = 0;
    logic wr_prev = 1'b0;

    logic [DW-1:0] exp_regs [NR];

    spi_regfile_peripheral #(
        .NUM_REGS   (NR),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .copi     (copi),
        .ncs      (ncs),
        .cipo     (cipo),
        .cipo_oe  (cipo_oe),
        .regs_out (regs_out),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled clear of the active edge.
    always @(posedge clk) begin
        #2;
        if (wr_pulse === 1'b1) wr_cnt++;
        if (wr_pulse === 1'b1 && wr_prev !== 1'b1) wr_rise++;
        if (frame_err === 1'b1) err_cnt++;
        wr_prev = wr_pulse;
    end

    function automatic logic [NR*DW-1:0] exp_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
        return v;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = bits[i];
            clks(HALF);
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
        copi = 1'b0;
    endtask

    task automatic do_frame(input logic [31:0] bits, input int n, input int gap);
        ncs = 1'b0;
        clks(HALF);
        shift_bits(bits, n);
        clks(HALF);
        ncs = 1'b1;
        clks(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clks(3);
        n_checks++; if (regs_out !== '0) begin n_fail++;
            $display("FAIL reset_regs: got %h expected 0", regs_out); end
        n_checks++; if (cipo !== 1'b0) begin n_fail++;
            $display("FAIL reset_cipo: got %b expected 0", cipo); end
        n_checks++; if (cipo_oe !== 1'b0) begin n_fail++;
            $display("FAIL reset_cipo_oe: got %b expected 0", cipo_oe); end
        n_checks++; if (wr_pulse !== 1'b0) begin n_fail++;
            $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
        n_checks++; if (wr_addr !== '0) begin n_fail++;
            $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++;
            $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst_n = 1'b1;
        clks(12);
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        ncs = 1'b0;
        clks(HALF);
        shift_bits(32'h80F0, 16);
        clks(HALF);
        ncs = 1'b1;
        clks(SS + 1);
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL write_early: got %h expected %h", regs_out, exp_vec()); end
        clks(1);
        exp_regs[0] = 8'hF0;
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL write_latency: got %h expected %h", regs_out, exp_vec()); end
        n_checks++; if (wr_pulse !== 1'b1) begin n_fail++;
            $display("FAIL write_pulse_high: got %b expected 1", wr_pulse); end
        clks(1);
        n_checks++; if (wr_pulse !== 1'b0) begin n_fail++;
            $display("FAIL write_pulse_low: got %b expected 0", wr_pulse); end
        clks(10);
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++;
            $display("FAIL write_pulse_cycles: got %0d expected 1", wr_cnt - w0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++;
            $display("FAIL write_no_err: got %0d expected 0", err_cnt - e0); end
        n_checks++; if (wr_addr !== 7'd0) begin n_fail++;
            $display("FAIL write_addr: got %h expected 0", wr_addr); end
    endtask

    task automatic test_bad_addr();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        do_frame(32'h8955, 16, 12);
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL bad_addr_regs: got %h expected %h", regs_out, exp_vec()); end
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++;
            $display("FAIL bad_addr_err: got %0d expected 1", err_cnt - e0); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++;
            $display("FAIL bad_addr_wr: got %0d expected 0", wr_cnt - w0); end
    endtask

    task automatic test_short_long();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        do_frame(32'h813C >> 6, 10, 12);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++;
            $display("FAIL short_err: got %0d expected 1", err_cnt - e0); end
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL short_regs: got %h expected %h", regs_out, exp_vec()); end
        do_frame(32'h10279, 17, 12);
        n_checks++; if (err_cnt - e0 !== 2) begin n_fail++;
            $display("FAIL long_err: got %0d expected 2", err_cnt - e0); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++;
            $display("FAIL long_wr: got %0d expected 0", wr_cnt - w0); end
        do_frame(32'h813C, 16, 12);
        exp_regs[1] = 8'h3C;
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL recover_regs: got %h expected %h", regs_out, exp_vec()); end
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++;
            $display("FAIL recover_wr: got %0d expected 1", wr_cnt - w0); end
        n_checks++; if (wr_addr !== 7'd1) begin n_fail++;
            $display("FAIL recover_addr: got %h expected 1", wr_addr); end
        n_checks++; if (err_cnt - e0 !== 2) begin n_fail++;
            $display("FAIL recover_err: got %0d expected 2", err_cnt - e0); end
    endtask

    task automatic test_read();
        int w0, e0;
        logic [DW-1:0] rd = 8'hA5;
        do_frame(32'h82A5, 16, 12);
        exp_regs[2] = 8'hA5;
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL read_setup_regs: got %h expected %h", regs_out, exp_vec()); end
        w0 = wr_cnt;
        e0 = err_cnt;
        ncs = 1'b0;
        clks(HALF);
        n_checks++; if (cipo_oe !== 1'b0) begin n_fail++;
            $display("FAIL read_oe_cmd: got %b expected 0", cipo_oe); end
        shift_bits(32'h02, 8);
        for (int i = DW - 1; i >= 0; i--) begin
            copi = 1'b0;
            clks(HALF);
            n_checks++; if (cipo !== (RB ? rd[i] : 1'b0)) begin n_fail++;
                $display("FAIL read_bit%0d: got %b expected %b", i, cipo, RB ? rd[i] : 1'b0); end
            n_checks++; if (cipo_oe !== RB) begin n_fail++;
                $display("FAIL read_oe_bit%0d: got %b expected %b", i, cipo_oe, RB); end
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
        clks(HALF);
        n_checks++; if (cipo_oe !== 1'b0) begin n_fail++;
            $display("FAIL read_oe_wait: got %b expected 0", cipo_oe); end
        ncs = 1'b1;
        clks(12);
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++;
            $display("FAIL read_err: got %0d expected 0", err_cnt - e0); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++;
            $display("FAIL read_wr: got %0d expected 0", wr_cnt - w0); end
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL read_regs: got %h expected %h", regs_out, exp_vec()); end
        // Out-of-range read: an error only when read-back is built in.
        do_frame(32'h0900, 16, 12);
        n_checks++; if (err_cnt - e0 !== (RB ? 1 : 0)) begin n_fail++;
            $display("FAIL read_bad_addr_err: got %0d expected %0d", err_cnt - e0, RB ? 1 : 0); end
    endtask

    task automatic test_reset_midframe();
        int w0;
        ncs = 1'b0;
        clks(HALF);
        shift_bits(32'h8577 >> 11, 5);
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        w0 = wr_cnt;
        shift_bits(32'h8577 & 32'h7FF, 11);
        clks(HALF);
        ncs = 1'b1;
        clks(12);
        n_checks++; if (regs_out !== '0) begin n_fail++;
            $display("FAIL midreset_regs: got %h expected 0", regs_out); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++;
            $display("FAIL midreset_wr: got %0d expected 0", wr_cnt - w0); end
        do_frame(32'h8511, 16, 12);
        exp_regs[5] = 8'h11;
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL midreset_next_regs: got %h expected %h", regs_out, exp_vec()); end
        n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++;
            $display("FAIL midreset_next_wr: got %0d expected 1", wr_cnt - w0); end
        n_checks++; if (wr_addr !== 7'd5) begin n_fail++;
            $display("FAIL midreset_next_addr: got %h expected 5", wr_addr); end
    endtask

    task automatic test_back_to_back();
        int r0 = wr_rise;
        int e0 = err_cnt;
        do_frame(32'h8333, 16, SS + 2);
        do_frame(32'h8444, 16, 12);
        exp_regs[3] = 8'h33;
        exp_regs[4] = 8'h44;
        n_checks++; if (regs_out !== exp_vec()) begin n_fail++;
            $display("FAIL b2b_regs: got %h expected %h", regs_out, exp_vec()); end
        n_checks++; if (wr_rise - r0 !== 2) begin n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 2", wr_rise - r0); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++;
            $display("FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
        n_checks++; if (wr_addr !== 7'd4) begin n_fail++;
            $display("FAIL b2b_addr: got %h expected 4", wr_addr); end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        test_reset();
        test_write();
        test_bad_addr();
        test_short_long();
        test_read();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regfile_peripheral.md
Name: spi_regfile_peripheral

Overview:
Parametrised SPI (mode 0) target exposing a bank of NUM_REGS control registers of DATA_W bits each. It succeeds the fixed two-register SPI peripheral that feeds the PWM enable and duty registers. This block adds per-register addressing, frame validation, a write strobe and optional read-back. It sits between the ui_in SPI pins and the PWM and other peripherals, all in the single clk domain.

Parameters:
NUM_REGS, 8, number of implemented registers (1..2**ADDR_W)
DATA_W, 8, register and data-field width in bits
ADDR_W, 7, address-field width in bits
SYNC_STAGES, 2, synchroniser flops on sclk/copi/ncs (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
sclk  in  1  SPI clock from the controller (asynchronous)
copi  in  1  controller-out data (asynchronous)
ncs  in  1  chip select, active-low (asynchronous)
cipo  out  1  controller-in data
cipo_oe  out  1  high while the block drives cipo
regs_out  out  NUM_REGS*DATA_W  flattened registers; reg i at [i*DATA_W +: DATA_W]
wr_pulse  out  1  one-cycle pulse when a write commits
wr_addr  out  ADDR_W  address of the last committed write
frame_err  out  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset is synchronous, active-low; only clk is used. On reset all outputs are 0: regs_out, cipo, cipo_oe, wr_pulse, wr_addr, frame_err. Synchroniser and edge-detect flops reset to idle values (sclk=0, ncs=1). FSM goes to IDLE.
- Frame format: FRAME_LEN = 1+ADDR_W+DATA_W bits, MSB first. Bit 0 is R/W (1=write, 0=read), then the address, then the data.
- Inputs pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Bits are sampled on a synchronised sclk rise. Shifting out happens on a synchronised sclk fall.
- The controller must hold each sclk phase for at least SYNC_STAGES+2 clk cycles.
- FSM states:
  - IDLE: on a synced ncs fall, clear bit_cnt and go to CMD.
  - CMD: shift 1+ADDR_W bits. At completion:
    - Write, or read with SPI_READBACK_EN off: go to DATA.
    - Read with SPI_READBACK_EN on and addr<NUM_REGS: load tx_shift with reg[addr] and go to DATA.
  - DATA: shift DATA_W bits; then go to WAIT.
  - WAIT: further sclk rises set an overflow flag. On a synced ncs rise, the frame is evaluated (see below) and the FSM returns to IDLE.
  - Synced ncs rise in CMD or DATA (short frame): discard the frame, pulse frame_err, go to IDLE.
- Write commit: the frame is a write, exactly FRAME_LEN bits were received, no overflow, and addr<NUM_REGS.
  - Only then is the register updated, on the clk edge that detects the ncs rise.
  - On that same edge, wr_pulse is asserted for 1 cycle and wr_addr is updated.
  - Latency from raw ncs rise to new regs_out is SYNC_STAGES+2 clk edges.
- Discarded frames pulse frame_err and leave all registers unchanged: addr>=NUM_REGS, short frame, or overflow. A complete, valid read frame commits nothing and raises no error.
- Registers are written only at frame end; a partial frame never corrupts regs_out.
- Reset mid-frame: clears everything. The block then ignores sclk until a synced ncs high is seen, so the remainder of an interrupted frame is never decoded.
- ncs rise and sclk rise detected in the same cycle: the ncs rise wins, and that sclk edge is not counted.
- Address bits above clog2(NUM_REGS) take part in the range check; they are never truncated.

Optional Feature:
SPI_READBACK_EN.
- Defined:
  - In DATA of a valid read frame, cipo = tx_shift MSB and cipo_oe = 1.
  - tx_shift shifts left on each synced sclk fall, so the first data bit is valid before the first data-phase sclk rise.
  - A read with addr>=NUM_REGS drives cipo=0 and pulses frame_err at ncs rise.
- Not defined: cipo and cipo_oe are tied 0. Read frames are accepted and ignored (no frame_err if the length is correct).

Test Plan:
- Write frame R/W=1, addr=0, data=0xF0 (16 bits, default params) -> regs_out[7:0]=0xF0 SYNC_STAGES+2 clks after ncs rise; wr_pulse high exactly 1 cycle; wr_addr=0; other regs 0.
- Write addr=9, data=0x55 with NUM_REGS=8 -> regs_out unchanged; frame_err 1 pulse; no wr_pulse.
- Write addr=1, 10 bits then ncs high -> discarded, frame_err pulse. Same with 17 bits -> discarded. A following valid write of 0x3C to addr 1 succeeds.
- With SPI_READBACK_EN: write 0xA5 to reg 2, then read addr 2 -> cipo presents 1,0,1,0,0,1,0,1 on successive data-phase sclk rises; cipo_oe high only during DATA. Without the macro: cipo=0 throughout.
- Assert rst_n low for 2 clks after 5 bits of a write with ncs held low, release, clock 11 more bits, raise ncs -> no write, regs_out=0. The next full frame is accepted.
- Back-to-back writes to regs 3 and 4 separated by 1 ncs-high period of SYNC_STAGES+2 clks -> both commit with two separate wr_pulse events.
